credit_delay_queue: RTL and testbench
=====================================

Name: credit_delay_queue

Overview:
- Parametrised per-output-port credit-return staging block for the NoC router.
- Holds returned virtual-channel credits in one circular queue per port. Each credit is released to the upstream credit path only after a programmable credit delay has elapsed on an internal cycle counter.
- Replaces the fixed-size, externally-timed credit staging store with configurable port count, depth, VC width and counter width.
- Adds a valid/ready release handshake, full/overflow reporting, counter wrap-safe comparison, and a synchronous flush.

Parameters:
- NUM_PORTS, 4, number of independent credit queues (one per output port).
- DEPTH, 16, entries per queue; must be a power of two, at least 2.
- VC_BITS, 5, width of the VC identifier carried by each credit.
- CYCLE_W, 16, width of the internal cycle counter and stored release stamp.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush of all queues and overflow flags.
- cfg_we  input  1  load cfg_delay into the delay register.
- cfg_delay  input  CYCLE_W  credit delay in cycles; legal range 0 .. 2^(CYCLE_W-1)-1.
- enq_valid  input  NUM_PORTS  per-port credit push.
- enq_vc  input  NUM_PORTS*VC_BITS  per-port VC, port p at [p*VC_BITS +: VC_BITS].
- cr_valid  output  NUM_PORTS  head credit of port p is due.
- cr_vc  output  NUM_PORTS*VC_BITS  head VC of port p, packed as enq_vc.
- cr_ready  input  NUM_PORTS  consumer pops head of port p when cr_valid[p] is also high.
- full  output  NUM_PORTS  port p holds DEPTH entries.
- overflow  output  NUM_PORTS  sticky: a push to port p was dropped.
- idle  output  1  all queues empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Cycle counter, delay register, head/tail pointers, counts and overflow all go to 0.
  - Outputs: cr_valid=0, cr_vc=0, full=0, overflow=0, idle=1.
- Cycle counter:
  - Increments by 1 every cycle and wraps modulo 2^CYCLE_W.
  - clr does not reset it.
- Delay register:
  - On cfg_we, takes cfg_delay at the next edge.
  - Affects only credits pushed after that edge; stored entries keep their stamp.
- Push (port p):
  - Condition: enq_valid[p] and space available.
  - Writes {stamp = now + delay, vc} at the tail. The tail pointer wraps modulo DEPTH and the count increments.
  - Uses the delay value held before any same-cycle cfg_we.
- Due test:
  - cr_valid[p] is combinational: count != 0 and the MSB of (now - head.stamp) mod 2^CYCLE_W is 0.
  - This makes the comparison correct across counter wrap.
- Release latency:
  - A credit pushed at the edge where now=T is first valid when now=T+D.
  - Minimum latency is 1 cycle when D=0.
- Ordering:
  - Release is strictly FIFO per port; a due entry behind a non-due head waits.
  - Ports are fully independent.
- Pop: cr_valid[p] and cr_ready[p] advances the head (wrap modulo DEPTH) and decrements the count.
- cr_vc[p]:
  - Equals the head VC whenever count != 0, regardless of cr_valid.
  - 0 when empty.
- Full:
  - full[p] = (count == DEPTH).
  - A push while full with a same-cycle pop is accepted; count stays DEPTH.
  - A push while full without a pop is dropped, overflow[p] is set, and queue contents are unchanged.
- Empty: count 0 holds cr_valid low; a pop attempt is ignored.
- clr:
  - Zeroes all pointers, counts and overflow at the next edge.
  - Overrides any same-cycle push or pop; cfg_we in the same cycle still takes effect.
- idle = all counts zero (combinational).
- Reset mid-operation discards all queued credits immediately; no credit is released after rst_n rises until a new push matures.

Test Plan:
- Delay 3; push vc=5 on port 0 at now=10 -> cr_valid[0] low at now 11,12; high with cr_vc=5 at now=13; pop with cr_ready -> valid low and idle=1 next cycle.
- Delay 0; push vc=2 on port 1 -> cr_valid[1] high the following cycle; hold cr_ready low -> remains valid and the entry is retained.
- DEPTH=16, delay 100; push 16 credits to port 2 -> full[2]=1; 17th push -> dropped, overflow[2]=1, count stays 16; push together with a pop once due -> accepted, full stays 1.
- CYCLE_W=8, delay 20; push at now=250 -> cr_valid high at now=14 (post-wrap), not before.
- Push vc=1 delay 50 then cfg_delay=2 and push vc=7 -> vc=7 is not released until vc=1 is released at T+50 and popped (FIFO order).
- Fill ports 0-3, assert clr with simultaneous pushes -> all empty, overflow=0, idle=1 next cycle; async rst_n pulse mid-delay -> cr_valid stays 0 afterwards.

Source files
------------

// File: rtl/credit_delay_queue.sv
`default_nettype none
// ============================================================================
// Module   : credit_delay_queue
// Brief    : Per-port circular credit queues; each credit is released only
//            once a programmable delay has elapsed on a free-running counter.
// Revision : 1.0
// ============================================================================
module credit_delay_queue #(
    parameter int NUM_PORTS = 4,
    parameter int DEPTH     = 16,
    parameter int VC_BITS   = 5,
    parameter int CYCLE_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           cfg_we,
    input  logic [CYCLE_W-1:0]             cfg_delay,
    input  logic [NUM_PORTS-1:0]           enq_valid,
    input  logic [NUM_PORTS*VC_BITS-1:0]   enq_vc,
    output logic [NUM_PORTS-1:0]           cr_valid,
    output logic [NUM_PORTS*VC_BITS-1:0]   cr_vc,
    input  logic [NUM_PORTS-1:0]           cr_ready,
    output logic [NUM_PORTS-1:0]           full,
    output logic [NUM_PORTS-1:0]           overflow,
    output logic                           idle
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [CYCLE_W-1:0]   now_q;
    logic [CYCLE_W-1:0]   delay_q;
    logic [CYCLE_W-1:0]   w_stamp;
    logic [NUM_PORTS-1:0] w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now_q   <= '0;
            delay_q <= '0;
        end else begin
            now_q <= now_q + 1'b1;
            if (cfg_we) begin
                delay_q <= cfg_delay;
            end
        end
    end

    // Stamp uses the delay held before any same-cycle reprogramming.
    assign w_stamp = now_q + delay_q;

    genvar p;
    generate
        for (p = 0; p < NUM_PORTS; p++) begin : g_port
            logic [CYCLE_W-1:0] stamp_q [DEPTH];
            logic [VC_BITS-1:0] vc_q    [DEPTH];
            logic [PTR_W-1:0]   head_q, head_d;
            logic [PTR_W-1:0]   tail_q, tail_d;
            logic [CNT_W-1:0]   count_q, count_d;
            logic               ovf_q, ovf_d;
            logic [CYCLE_W-1:0] w_age;
            logic               w_nonempty;
            logic               w_full;
            logic               w_due;
            logic               w_pop;
            logic               w_push;

            assign w_nonempty = (count_q != '0);
            assign w_full     = (count_q == CNT_FULL);
            // Modular age: MSB clear means the stamp is at or behind now.
            assign w_age      = now_q - stamp_q[head_q];
            assign w_due      = w_nonempty & ~w_age[CYCLE_W-1];
            assign w_pop      = w_due & cr_ready[p];
            assign w_push     = enq_valid[p] & (~w_full | w_pop);

            always_comb begin
                head_d  = head_q;
                tail_d  = tail_q;
                count_d = count_q;
                ovf_d   = ovf_q;
                if (clr) begin
                    head_d  = '0;
                    tail_d  = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else begin
                    if (w_pop) begin
                        head_d = head_q + 1'b1;
                    end
                    if (w_push) begin
                        tail_d = tail_q + 1'b1;
                    end
                    case ({w_push, w_pop})
                        2'b10:   count_d = count_q + 1'b1;
                        2'b01:   count_d = count_q - 1'b1;
                        default: count_d = count_q;
                    endcase
                    if (enq_valid[p] && !w_push) begin
                        ovf_d = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    head_q  <= '0;
                    tail_q  <= '0;
                    count_q <= '0;
                    ovf_q   <= 1'b0;
                end else begin
                    head_q  <= head_d;
                    tail_q  <= tail_d;
                    count_q <= count_d;
                    ovf_q   <= ovf_d;
                end
            end

            always_ff @(posedge clk) begin
                if (w_push && !clr) begin
                    stamp_q[tail_q] <= w_stamp;
                    vc_q[tail_q]    <= enq_vc[p*VC_BITS +: VC_BITS];
                end
            end

            assign cr_valid[p]                  = w_due;
            assign cr_vc[p*VC_BITS +: VC_BITS]  = w_nonempty ? vc_q[head_q] : '0;
            assign full[p]                      = w_full;
            assign overflow[p]                  = ovf_q;
            assign w_empty[p]                   = ~w_nonempty;
        end
    endgenerate

    assign idle = &w_empty;

endmodule
`default_nettype wire

// File: tb/tb_credit_delay_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_credit_delay_queue
// Brief    : Directed self-checking bench for credit_delay_queue (8-bit counter).
// Revision : 1.0
// ============================================================================
module tb_credit_delay_queue;

    localparam int NP = 4;
    localparam int DP = 16;
    localparam int VB = 5;
    localparam int CW = 8;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              cfg_we;
    logic [CW-1:0]     cfg_delay;
    logic [NP-1:0]     enq_valid;
    logic [NP*VB-1:0]  enq_vc;
    logic [NP-1:0]     cr_valid;
    logic [NP*VB-1:0]  cr_vc;
    logic [NP-1:0]     cr_ready;
    logic [NP-1:0]     full;
    logic [NP-1:0]     overflow;
    logic              idle;

    int n_tests = 0;
    int n_fail  = 0;

    logic [CW-1:0] now_m;
    logic [CW-1:0] t0;

    credit_delay_queue #(
        .NUM_PORTS (NP),
        .DEPTH     (DP),
        .VC_BITS   (VB),
        .CYCLE_W   (CW)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .cfg_we    (cfg_we),
        .cfg_delay (cfg_delay),
        .enq_valid (enq_valid),
        .enq_vc    (enq_vc),
        .cr_valid  (cr_valid),
        .cr_vc     (cr_vc),
        .cr_ready  (cr_ready),
        .full      (full),
        .overflow  (overflow),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference copy of the free-running cycle counter.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) now_m <= '0;
        else        now_m <= now_m + 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_now(input logic [CW-1:0] t);
        int k = 0;
        while (now_m != t && k < 300) begin
            tick();
            k++;
        end
        chk("wait_now", 32'(now_m), 32'(t));
    endtask

    task automatic set_delay(input logic [CW-1:0] d);
        cfg_we    = 1'b1;
        cfg_delay = d;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic drive_push(input int p, input logic [VB-1:0] vc);
        enq_valid[p]        = 1'b1;
        enq_vc[p*VB +: VB]  = vc;
    endtask

    function automatic logic [VB-1:0] head_vc(input int p);
        return cr_vc[p*VB +: VB];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        cfg_we    = 1'b0;
        cfg_delay = '0;
        enq_valid = '0;
        enq_vc    = '0;
        cr_ready  = '0;
        repeat (3) tick();

        chk("rst_valid", cr_valid, 0);
        chk("rst_vc",    cr_vc,    0);
        chk("rst_full",  full,     0);
        chk("rst_ovf",   overflow, 0);
        chk("rst_idle",  idle,     1);
        rst_n = 1'b1;

        // Delay 3, push at now=10: due at 13.
        set_delay(8'd3);
        wait_now(8'd10);
        drive_push(0, 5'd5);
        tick();
        enq_valid = '0;
        chk("d3_now11", cr_valid[0], 0);
        tick();
        chk("d3_now12", cr_valid[0], 0);
        tick();
        chk("d3_now13", cr_valid[0], 1);
        chk("d3_vc",    head_vc(0),  5);
        chk("d3_busy",  idle,        0);
        cr_ready[0] = 1'b1;
        tick();
        cr_ready = '0;
        chk("d3_popped", cr_valid[0], 0);
        chk("d3_idle",   idle,        1);

        // Pop on empty is ignored.
        cr_ready = '1;
        tick();
        cr_ready = '0;
        chk("empty_pop_idle", idle, 1);

        // Delay 0: valid the very next cycle, retained while not ready.
        set_delay(8'd0);
        drive_push(1, 5'd2);
        tick();
        enq_valid = '0;
        chk("d0_valid", cr_valid[1], 1);
        chk("d0_vc",    head_vc(1),  2);
        repeat (3) tick();
        chk("d0_hold_valid", cr_valid[1], 1);
        chk("d0_hold_vc",    head_vc(1),  2);
        cr_ready[1] = 1'b1;
        tick();
        cr_ready = '0;
        chk("d0_idle", idle, 1);

        // Fill port 2, overflow, then push with pop while full.
        set_delay(8'd100);
        t0 = now_m;
        for (int i = 0; i < 16; i++) begin
            drive_push(2, 5'(i));
            tick();
        end
        enq_valid = '0;
        chk("fill_full", full[2],     1);
        chk("fill_ovf0", overflow[2], 0);
        drive_push(2, 5'd20);
        tick();
        enq_valid = '0;
        chk("ovf_set",     overflow[2], 1);
        chk("ovf_full",    full[2],     1);
        chk("ovf_head",    head_vc(2),  0);
        chk("ovf_others",  overflow,    4'b0100);
        wait_now(t0 + 8'd99);
        chk("full_notdue", cr_valid[2], 0);
        tick();
        chk("full_due", cr_valid[2], 1);
        chk("full_vc0", head_vc(2),  0);
        drive_push(2, 5'd21);
        cr_ready[2] = 1'b1;
        tick();
        enq_valid = '0;
        cr_ready  = '0;
        chk("pushpop_full",  full[2],     1);
        chk("pushpop_ovf",   overflow[2], 1);
        chk("pushpop_vc1",   head_vc(2),  1);
        chk("pushpop_valid", cr_valid[2], 1);

        // Counter wrap: push at 250 with delay 20 matures at 14.
        set_delay(8'd20);
        wait_now(8'd250);
        drive_push(3, 5'd9);
        tick();
        enq_valid = '0;
        chk("wrap_now251", cr_valid[3], 0);
        chk("wrap_vc251",  head_vc(3),  9);
        wait_now(8'd13);
        chk("wrap_now13", cr_valid[3], 0);
        tick();
        chk("wrap_now14", cr_valid[3], 1);
        cr_ready[3] = 1'b1;
        tick();
        cr_ready = '0;
        chk("wrap_popped", cr_valid[3], 0);

        // FIFO order: due vc=7 waits behind vc=1; push uses pre-update delay.
        set_delay(8'd50);
        t0 = now_m;
        drive_push(0, 5'd1);
        cfg_we    = 1'b1;
        cfg_delay = 8'd2;
        tick();
        cfg_we    = 1'b0;
        drive_push(0, 5'd7);
        tick();
        enq_valid = '0;
        wait_now(t0 + 8'd49);
        chk("fifo_blocked", cr_valid[0], 0);
        chk("fifo_headvc",  head_vc(0),  1);
        tick();
        chk("fifo_due1", cr_valid[0], 1);
        chk("fifo_vc1",  head_vc(0),  1);
        cr_ready[0] = 1'b1;
        tick();
        chk("fifo_due7", cr_valid[0], 1);
        chk("fifo_vc7",  head_vc(0),  7);
        tick();
        cr_ready = '0;
        chk("fifo_empty", cr_valid[0], 0);

        // Fill all ports, then clr with simultaneous pushes.
        for (int i = 0; i < 4; i++) begin
            drive_push(0, 5'(i));
            drive_push(1, 5'(i));
            drive_push(3, 5'(i));
            tick();
        end
        enq_valid = '0;
        chk("pre_clr_idle", idle, 0);
        clr       = 1'b1;
        enq_valid = '1;
        enq_vc    = '1;
        cr_ready  = '1;
        tick();
        clr       = 1'b0;
        enq_valid = '0;
        cr_ready  = '0;
        chk("clr_idle",  idle,     1);
        chk("clr_ovf",   overflow, 0);
        chk("clr_full",  full,     0);
        chk("clr_valid", cr_valid, 0);
        chk("clr_vc",    cr_vc,    0);

        // Async reset mid-delay discards the queued credit.
        set_delay(8'd10);
        drive_push(1, 5'd6);
        tick();
        enq_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_idle",  idle,     1);
        chk("arst_valid", cr_valid, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("post_rst_valid", cr_valid, 0);
        end
        // Delay register returned to 0 on reset.
        drive_push(0, 5'd3);
        tick();
        enq_valid = '0;
        chk("post_rst_d0_valid", cr_valid[0], 1);
        chk("post_rst_d0_vc",    head_vc(0),  3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
